// File: rtl/asset_loader_if.sv
// ioctl download bus plus the serialised byte-write bus of asset_loader.
// master = bridge/memory side, slave = loader side.
interface asset_loader_if #(
  parameter int unsigned IOCTL_WIDTH = 16,
  parameter int unsigned NUM_REGIONS = 4
);
  localparam int unsigned SEL_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  logic                   ioctl_download;
  logic                   ioctl_wr;
  logic [24:0]            ioctl_addr;
  logic [IOCTL_WIDTH-1:0] ioctl_dout;
  logic                   ioctl_wait;
  logic                   wr_8bit;
  logic [SEL_W-1:0]       region_sel;
  logic [25:0]            addr_8bit;
  logic [7:0]             data_8bit;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_wait, wr_8bit, region_sel, addr_8bit, data_8bit
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_wait, wr_8bit, region_sel, addr_8bit, data_8bit
  );
endinterface

// File: rtl/asset_loader.sv
// Download loader: serialises ioctl words to bytes, decodes regions, parses the header region.
// Optional HEADER_CHECKSUM_EN: header byte 47 must equal the mod-256 sum of bytes 0..46.
module asset_loader #(
  parameter int unsigned               IOCTL_WIDTH      = 16,
  parameter int unsigned               NUM_REGIONS      = 4,
  parameter logic [NUM_REGIONS*25-1:0] REGION_START     = {25'h187250, 25'h17BB80, 25'h80, 25'h0},
  parameter logic [7:0]                EXPECTED_VERSION = 8'h01
) (
  input  logic         clk,
  input  logic         reset_n,
  asset_loader_if.slave ioctl,
  output logic [7:0]   mpu,
  output logic [7:0]   screen_config,
  output logic [11:0]  screen_width,
  output logic [11:0]  screen_height,
  output logic [255:0] input_s_config,
  output logic [7:0]   input_b_config,
  output logic [7:0]   input_ba_config,
  output logic [7:0]   input_acl_config,
  output logic         header_valid,
  output logic         header_error,
  output logic         overrun,
  output logic         load_done
);
  localparam int unsigned BYTES = IOCTL_WIDTH / 8;
  localparam int unsigned SEL_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [2:0] {StIdle, StHeader, StPayload, StError, StDone} state_e;

  state_e                 state_q;
  logic                   dl_q;
  logic                   active_q;
  logic [IDX_W-1:0]       left_q;
  logic [IOCTL_WIDTH-1:0] shift_q;
  logic                   wr_8bit_q;
  logic [SEL_W-1:0]       region_sel_q;
  logic [25:0]            addr_8bit_q;
  logic [7:0]             data_8bit_q;
  logic [7:0]             version_q, mpu_q, screen_config_q;
  logic [11:0]            screen_width_q, screen_height_q;
  logic [255:0]           input_s_config_q;
  logic [7:0]             input_b_config_q, input_ba_config_q, input_acl_config_q;
  logic                   header_valid_q, header_error_q, overrun_q, load_done_q;
`ifdef HEADER_CHECKSUM_EN
  logic [7:0]             sum_q;
`endif

  logic             rise, accept, parse_en, hdr_last, hdr_ok;
  logic [SEL_W-1:0] dec_sel;
  logic [24:0]      dec_start;
  logic [25:0]      dec_base;
  logic [4:0]       s_idx;

  // Starts are ascending, so the last match is the highest region containing the address.
  always_comb begin
    dec_sel   = '0;
    dec_start = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (ioctl.ioctl_addr >= REGION_START[i*25 +: 25]) begin
        dec_sel   = SEL_W'(i);
        dec_start = REGION_START[i*25 +: 25];
      end
    end
  end

  assign dec_base = 26'(ioctl.ioctl_addr - dec_start) * 26'(BYTES);
  assign rise     = ioctl.ioctl_download & ~dl_q;
  assign accept   = ioctl.ioctl_wr & ~active_q;
  assign parse_en = wr_8bit_q && (region_sel_q == '0) &&
                    (state_q == StHeader || state_q == StPayload || state_q == StError);
  assign hdr_last = parse_en && (addr_8bit_q == 26'd47);
  assign s_idx    = 5'(addr_8bit_q - 26'd8);

`ifdef HEADER_CHECKSUM_EN
  assign hdr_ok = (version_q == EXPECTED_VERSION) && (data_8bit_q == sum_q);
`else
  assign hdr_ok = (version_q == EXPECTED_VERSION);
`endif

  assign ioctl.ioctl_wait = ioctl.ioctl_wr | active_q;
  assign ioctl.wr_8bit    = wr_8bit_q;
  assign ioctl.region_sel = region_sel_q;
  assign ioctl.addr_8bit  = addr_8bit_q;
  assign ioctl.data_8bit  = data_8bit_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= StIdle;
      // Held high so a download already in progress at reset release is not seen as a start.
      dl_q               <= 1'b1;
      active_q           <= 1'b0;
      left_q             <= '0;
      shift_q            <= '0;
      wr_8bit_q          <= 1'b0;
      region_sel_q       <= '0;
      addr_8bit_q        <= '0;
      data_8bit_q        <= '0;
      version_q          <= '0;
      mpu_q              <= '0;
      screen_config_q    <= '0;
      screen_width_q     <= '0;
      screen_height_q    <= '0;
      input_s_config_q   <= '0;
      input_b_config_q   <= '0;
      input_ba_config_q  <= '0;
      input_acl_config_q <= '0;
      header_valid_q     <= 1'b0;
      header_error_q     <= 1'b0;
      overrun_q          <= 1'b0;
      load_done_q        <= 1'b0;
`ifdef HEADER_CHECKSUM_EN
      sum_q              <= '0;
`endif
    end else begin
      dl_q <= ioctl.ioctl_download;
      if (rise) begin
        state_q            <= StHeader;
        active_q           <= 1'b0;
        wr_8bit_q          <= 1'b0;
        version_q          <= '0;
        mpu_q              <= '0;
        screen_config_q    <= '0;
        screen_width_q     <= '0;
        screen_height_q    <= '0;
        input_s_config_q   <= '0;
        input_b_config_q   <= '0;
        input_ba_config_q  <= '0;
        input_acl_config_q <= '0;
        header_valid_q     <= 1'b0;
        header_error_q     <= 1'b0;
        overrun_q          <= 1'b0;
        load_done_q        <= 1'b0;
`ifdef HEADER_CHECKSUM_EN
        sum_q              <= '0;
`endif
      end else begin
        if (accept) begin
          active_q     <= 1'b1;
          left_q       <= IDX_W'(BYTES - 1);
          shift_q      <= ioctl.ioctl_dout >> 8;
          wr_8bit_q    <= (state_q != StError) || (dec_sel == '0);
          region_sel_q <= dec_sel;
          addr_8bit_q  <= dec_base;
          data_8bit_q  <= ioctl.ioctl_dout[7:0];
        end else if (active_q) begin
          if (left_q == '0) begin
            active_q  <= 1'b0;
            wr_8bit_q <= 1'b0;
          end else begin
            left_q      <= left_q - 1'b1;
            shift_q     <= shift_q >> 8;
            wr_8bit_q   <= (state_q != StError) || (region_sel_q == '0);
            addr_8bit_q <= addr_8bit_q + 26'd1;
            data_8bit_q <= shift_q[7:0];
          end
        end

        if (ioctl.ioctl_wr && active_q) overrun_q <= 1'b1;

        if (parse_en) begin
          case (addr_8bit_q) inside
            26'd0: version_q       <= data_8bit_q;
            26'd1: mpu_q           <= data_8bit_q;
            26'd2: screen_config_q <= data_8bit_q;
            26'd3: screen_width_q[7:0] <= data_8bit_q;
            26'd4: begin
              screen_width_q[11:8] <= data_8bit_q[3:0];
              screen_height_q[3:0] <= data_8bit_q[7:4];
            end
            26'd5: screen_height_q[11:4] <= data_8bit_q;
            [26'd8:26'd39]: input_s_config_q[{s_idx, 3'b000} +: 8] <= data_8bit_q;
            26'd40: input_b_config_q   <= data_8bit_q;
            26'd41: input_ba_config_q  <= data_8bit_q;
            26'd42: input_acl_config_q <= data_8bit_q;
            default: ;
          endcase
`ifdef HEADER_CHECKSUM_EN
          if (addr_8bit_q <= 26'd46) sum_q <= sum_q + data_8bit_q;
`endif
        end

        case (state_q)
          StHeader: begin
            if (hdr_last) begin
              if (hdr_ok) begin
                state_q        <= StPayload;
                header_valid_q <= 1'b1;
              end else begin
                state_q        <= StError;
                header_error_q <= 1'b1;
              end
            end else if (!ioctl.ioctl_download) begin
              state_q        <= StError;
              header_error_q <= 1'b1;
            end
          end
          StPayload, StError: begin
            if (!ioctl.ioctl_download && !ioctl.ioctl_wait) begin
              state_q     <= StDone;
              load_done_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mpu              = mpu_q;
  assign screen_config    = screen_config_q;
  assign screen_width     = screen_width_q;
  assign screen_height    = screen_height_q;
  assign input_s_config   = input_s_config_q;
  assign input_b_config   = input_b_config_q;
  assign input_ba_config  = input_ba_config_q;
  assign input_acl_config = input_acl_config_q;
  assign header_valid     = header_valid_q;
  assign header_error     = header_error_q;
  assign overrun          = overrun_q;
  assign load_done        = load_done_q;
endmodule

// File: tb/tb_asset_loader.sv
// Scoreboard bench for asset_loader: 16-bit and 32-bit instances, byte stream checked by monitors.
module tb_asset_loader;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  asset_loader_if #(.IOCTL_WIDTH(16), .NUM_REGIONS(4)) b16 ();
  asset_loader_if #(.IOCTL_WIDTH(32), .NUM_REGIONS(4)) b32 ();

  logic [7:0]   mpu, scfg, bcfg, bacfg, aclcfg;
  logic [11:0]  sw, sh;
  logic [255:0] scfg_s;
  logic         hv, he, ov, ld;
  logic [7:0]   mpu2, scfg2, bcfg2, bacfg2, aclcfg2;
  logic [11:0]  sw2, sh2;
  logic [255:0] scfg_s2;
  logic         hv2, he2, ov2, ld2;

  asset_loader #(.IOCTL_WIDTH(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .ioctl(b16.slave),
    .mpu(mpu), .screen_config(scfg), .screen_width(sw), .screen_height(sh),
    .input_s_config(scfg_s), .input_b_config(bcfg), .input_ba_config(bacfg),
    .input_acl_config(aclcfg), .header_valid(hv), .header_error(he), .overrun(ov),
    .load_done(ld)
  );

  asset_loader #(.IOCTL_WIDTH(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .ioctl(b32.slave),
    .mpu(mpu2), .screen_config(scfg2), .screen_width(sw2), .screen_height(sh2),
    .input_s_config(scfg_s2), .input_b_config(bcfg2), .input_ba_config(bacfg2),
    .input_acl_config(aclcfg2), .header_valid(hv2), .header_error(he2), .overrun(ov2),
    .load_done(ld2)
  );

  typedef struct packed {
    logic [1:0]  sel;
    logic [25:0] addr;
    logic [7:0]  data;
  } byte_t;

  byte_t        q16[$];
  byte_t        q32[$];
  int           checks = 0;
  int           errors = 0;
  logic [7:0]   hdr[48];
  logic [255:0] s_exp;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (b16.wr_8bit === 1'b1) begin
      checks++;
      if (q16.size() == 0) begin
        errors++;
        $display("FAIL byte16: unexpected strobe sel %0d addr %0h data %0h, expected none",
                 b16.region_sel, b16.addr_8bit, b16.data_8bit);
      end else begin
        byte_t e;
        e = q16.pop_front();
        if ({b16.region_sel, b16.addr_8bit, b16.data_8bit} !== e) begin
          errors++;
          $display("FAIL byte16: got sel %0d addr %0h data %0h expected sel %0d addr %0h data %0h",
                   b16.region_sel, b16.addr_8bit, b16.data_8bit, e.sel, e.addr, e.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b32.wr_8bit === 1'b1) begin
      checks++;
      if (q32.size() == 0) begin
        errors++;
        $display("FAIL byte32: unexpected strobe sel %0d addr %0h data %0h, expected none",
                 b32.region_sel, b32.addr_8bit, b32.data_8bit);
      end else begin
        byte_t e;
        e = q32.pop_front();
        if ({b32.region_sel, b32.addr_8bit, b32.data_8bit} !== e) begin
          errors++;
          $display("FAIL byte32: got sel %0d addr %0h data %0h expected sel %0d addr %0h data %0h",
                   b32.region_sel, b32.addr_8bit, b32.data_8bit, e.sel, e.addr, e.data);
        end
      end
    end
  end

  task automatic wait_idle16();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (b16.ioctl_wait && n < 20);
    if (b16.ioctl_wait) begin
      errors++;
      $display("FAIL wait16_timeout: ioctl_wait still %0b expected 0", b16.ioctl_wait);
    end
  endtask

  task automatic wr16(input logic [24:0] a, input logic [15:0] d, input bit exp_strobe,
                      input logic [1:0] sel, input logic [25:0] base);
    @(posedge clk); #1;
    if (exp_strobe) begin
      q16.push_back({sel, base, d[7:0]});
      q16.push_back({sel, base + 26'd1, d[15:8]});
    end
    b16.ioctl_wr = 1'b1;
    b16.ioctl_addr = a;
    b16.ioctl_dout = d;
    @(posedge clk); #1;
    b16.ioctl_wr = 1'b0;
    wait_idle16();
  endtask

  task automatic header16();
    for (int w = 0; w < 24; w++)
      wr16(25'(w), {hdr[2*w+1], hdr[2*w]}, 1'b1, 2'd0, 26'(2 * w));
    repeat (2) @(negedge clk);
  endtask

  task automatic set_dl16(input logic v);
    @(posedge clk); #1;
    b16.ioctl_download = v;
    repeat (4) @(negedge clk);
  endtask

  function automatic logic [7:0] hsum();
    logic [7:0] s = 8'h00;
    for (int i = 0; i < 47; i++) s = s + hdr[i];
    return s;
  endfunction

  initial begin
    int wcnt;
    b16.ioctl_download = 1'b0; b16.ioctl_wr = 1'b0; b16.ioctl_addr = '0; b16.ioctl_dout = '0;
    b32.ioctl_download = 1'b0; b32.ioctl_wr = 1'b0; b32.ioctl_addr = '0; b32.ioctl_dout = '0;
    for (int i = 0; i < 48; i++) hdr[i] = 8'(i);
    hdr[0] = 8'h01; hdr[1] = 8'h5A; hdr[2] = 8'h3C;
    hdr[3] = 8'hC0; hdr[4] = 8'h00; hdr[5] = 8'h0A; hdr[6] = 8'hFF; hdr[7] = 8'hFF;
    hdr[40] = 8'h11; hdr[41] = 8'h22; hdr[42] = 8'h33;
    for (int i = 43; i < 47; i++) hdr[i] = 8'hEE;
    hdr[47] = hsum();
    for (int k = 0; k < 32; k++) s_exp[8*k +: 8] = 8'(8 + k);

    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("reset_wr_8bit", b16.wr_8bit, 1'b0);
    chk("reset_wait", b16.ioctl_wait, 1'b0);
    chk("reset_flags", {hv, he, ov, ld}, 4'b0000);
    chk("reset_screen", {sw, sh, mpu, scfg}, '0);
    chk("reset_s_config", scfg_s, '0);

    // Download 1: first word, wait length, then a valid header
    set_dl16(1'b1);
    @(posedge clk); #1;
    q16.push_back({2'd0, 26'd0, 8'h01});
    q16.push_back({2'd0, 26'd1, 8'h01});
    b16.ioctl_wr = 1'b1; b16.ioctl_addr = 25'd0; b16.ioctl_dout = 16'h0101;
    wcnt = 0;
    @(negedge clk); if (b16.ioctl_wait) wcnt++;
    @(posedge clk); #1 b16.ioctl_wr = 1'b0;
    repeat (5) begin @(negedge clk); if (b16.ioctl_wait) wcnt++; end
    chk("wait_cycles", wcnt, 3);

    header16();
    chk("hdr_valid", {hv, he}, 2'b10);
    chk("screen_width", sw, 12'h0C0);
    chk("screen_height", sh, 12'h0A0);
    chk("mpu_scfg", {mpu, scfg}, 16'h5A3C);
    chk("s_config", scfg_s, s_exp);
    chk("b_ba_acl", {bcfg, bacfg, aclcfg}, 24'h112233);

    wr16(25'h187250, 16'hBEEF, 1'b1, 2'd3, 26'd0);
    wr16(25'h82, 16'h1234, 1'b1, 2'd1, 26'd4);
    wr16(25'd1, 16'h1055, 1'b1, 2'd0, 26'd2);
    repeat (2) @(negedge clk);
    chk("rewrite_scfg", scfg, 8'h55);
    chk("rewrite_width", {sw, sh}, {12'h010, 12'h0A0});
    chk("rewrite_state", {hv, he, ld}, 3'b100);

    // Back-to-back write: second word dropped
    @(posedge clk); #1;
    q16.push_back({2'd1, 26'h20, 8'h0D});
    q16.push_back({2'd1, 26'h21, 8'h0C});
    b16.ioctl_wr = 1'b1; b16.ioctl_addr = 25'h90; b16.ioctl_dout = 16'h0C0D;
    @(posedge clk); #1 b16.ioctl_addr = 25'h91; b16.ioctl_dout = 16'hFFFF;
    @(posedge clk); #1 b16.ioctl_wr = 1'b0;
    wait_idle16();
    chk("overrun", ov, 1'b1);

    set_dl16(1'b0);
    chk("done1", {hv, he, ld}, 3'b101);

    // Download 2: bad version
    set_dl16(1'b1);
    chk("restart_clear", {hv, he, ov, ld, mpu, sw}, '0);
    hdr[0] = 8'h02;
    header16();
    chk("bad_version", {hv, he}, 2'b01);
    wr16(25'h187250, 16'h1111, 1'b0, 2'd3, 26'd0);
    wr16(25'd0, 16'h7702, 1'b1, 2'd0, 26'd0);
    repeat (2) @(negedge clk);
    chk("error_region0_parse", mpu, 8'h77);
    set_dl16(1'b0);
    chk("done_after_error", {he, ld}, 2'b11);

    // Download 3: download ends inside the header
    set_dl16(1'b1);
    wr16(25'd0, 16'h5A01, 1'b1, 2'd0, 26'd0);
    set_dl16(1'b0);
    chk("short_header", {hv, he, ld}, 3'b011);

    // Download 4: async reset mid-download needs a fresh rising edge
    hdr[0] = 8'h01;
    hdr[47] = hsum();
    set_dl16(1'b1);
    wr16(25'd0, 16'h5A01, 1'b1, 2'd0, 26'd0);
    @(posedge clk); #1 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("midreset_clear", {hv, he, ov, ld, mpu}, '0);
    set_dl16(1'b0);
    chk("midreset_no_start", {hv, he, ld}, 3'b000);
    set_dl16(1'b1);
    header16();
    chk("restart_valid", {hv, he}, 2'b10);
    set_dl16(1'b0);

`ifdef HEADER_CHECKSUM_EN
    set_dl16(1'b1);
    hdr[47] = hsum() + 8'd1;
    header16();
    chk("checksum_bad", {hv, he}, 2'b01);
    set_dl16(1'b0);
    chk("checksum_done", ld, 1'b1);
`endif

    // 32-bit instance: region 2, four bytes per word
    @(posedge clk); #1 b32.ioctl_download = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    q32.push_back({2'd2, 26'd4, 8'hAA});
    q32.push_back({2'd2, 26'd5, 8'hBB});
    q32.push_back({2'd2, 26'd6, 8'hCC});
    q32.push_back({2'd2, 26'd7, 8'hDD});
    b32.ioctl_wr = 1'b1; b32.ioctl_addr = 25'h17BB81; b32.ioctl_dout = 32'hDDCCBBAA;
    @(posedge clk); #1 b32.ioctl_wr = 1'b0;
    repeat (8) @(negedge clk);
    chk("w32_wait_idle", b32.ioctl_wait, 1'b0);

    repeat (3) @(negedge clk);
    chk("q16_drained", q16.size(), 0);
    chk("q32_drained", q32.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
